// File: rtl/act_loader.sv
// act_loader: buffers upstream activation words and streams one tile per request to the activation buffer.
// Optional ACT_LOADER_STALL_CNT_EN adds a saturating count of underrun cycles.
module act_loader #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk_l,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_tile_words,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic              actbuf_wr_req,
  output logic              actbuf_wr_vld,
  output logic [DATA_W-1:0] actbuf_wr_data,
  output logic              busy,
  output logic              tile_done
`ifdef ACT_LOADER_STALL_CNT_EN
  , output logic [31:0]     stall_cnt
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state_q, state_d;
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0] rem_q, rem_d;
  logic vld_q, vld_d, done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic empty, full, push, pop;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push = in_vld && !full;
  // a dropped request stops popping in the same cycle it is seen low
  assign pop = state_q == FILL && actbuf_wr_req && !empty && rem_q != '0;
  assign in_rdy = !full;
  assign busy = state_q != IDLE;
  assign actbuf_wr_vld = vld_q;
  assign actbuf_wr_data = data_q;
  assign tile_done = done_q;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    vld_d = pop;
    done_d = pop && rem_q == CNT_W'(1);
    data_d = pop ? mem_q[rd_ptr_q[PTR_W-1:0]] : data_q;
    case (state_q)
      IDLE: if (actbuf_wr_req) begin
        state_d = FILL;
        rem_d = cfg_tile_words == '0 ? CNT_W'(1) : cfg_tile_words;
      end
      FILL: if (!actbuf_wr_req) state_d = IDLE;
        else if (pop) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      DONE: if (!actbuf_wr_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q <= vld_d;
      done_q <= done_d;
      data_q <= data_d;
    end
  end
  always_ff @(posedge clk_l) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= in_data;
  end
`ifdef ACT_LOADER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_cnt = stall_q;
  always_comb begin
    stall_d = (state_q == IDLE && actbuf_wr_req) ? '0 :
              (state_q == FILL && empty && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else stall_q <= stall_d;
  end
`endif
endmodule

// File: tb/tb_act_loader.sv
// tb_act_loader: directed scenario bench for act_loader.
module tb_act_loader;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam logic [DW-1:0] BASE = 64'hA5A5_0000_0000_0000;
  logic clk_l = 1'b0;
  logic rst_n = 1'b1;
  logic [CW-1:0] cfg_tile_words;
  logic [DW-1:0] in_data;
  logic in_vld, in_rdy, actbuf_wr_req, actbuf_wr_vld, busy, tile_done;
  logic [DW-1:0] actbuf_wr_data;
`ifdef ACT_LOADER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int nvec = 0;
  int nerr = 0;
  int pushed = 0;
  int popped = 0;

  act_loader #(.DATA_W(DW), .FIFO_DEPTH(8), .CNT_W(CW)) dut (
    .clk_l(clk_l), .rst_n(rst_n), .cfg_tile_words(cfg_tile_words),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .actbuf_wr_req(actbuf_wr_req), .actbuf_wr_vld(actbuf_wr_vld),
    .actbuf_wr_data(actbuf_wr_data), .busy(busy), .tile_done(tile_done)
`ifdef ACT_LOADER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk_l = ~clk_l;

  task automatic clk_step();
    logic a;
    in_data = BASE + DW'(pushed);
    a = in_vld && in_rdy;
    @(posedge clk_l);
    #1;
    if (a) pushed++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_vld = 1'b0;
    actbuf_wr_req = 1'b0;
    @(posedge clk_l);
    #1;
    rst_n = 1'b1;
    pushed = 0;
    popped = 0;
  endtask

  task automatic test_reset();
    cfg_tile_words = 16'd1;
    in_vld = 1'b0;
    actbuf_wr_req = 1'b0;
    in_data = '0;
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (actbuf_wr_vld !== 1'b0) begin nerr++; $display("FAIL reset_vld got %0b exp 0", actbuf_wr_vld); end
    nvec++; if (actbuf_wr_data !== '0) begin nerr++; $display("FAIL reset_data got %h exp 0", actbuf_wr_data); end
    nvec++; if (tile_done !== 1'b0) begin nerr++; $display("FAIL reset_done got %0b exp 0", tile_done); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %0b exp 0", busy); end
    nvec++; if (in_rdy !== 1'b1) begin nerr++; $display("FAIL reset_in_rdy got %0b exp 1", in_rdy); end
`ifdef ACT_LOADER_STALL_CNT_EN
    nvec++; if (stall_cnt !== 32'd0) begin nerr++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
`endif
    @(posedge clk_l);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int gaps = 0;
    do_reset();
    cfg_tile_words = 16'd27;
    in_vld = 1'b1;
    repeat (9) clk_step();
    nvec++; if (in_rdy !== 1'b0 || pushed != 8) begin nerr++; $display("FAIL basic_prefill got in_rdy=%0b accepted=%0d exp 0/8", in_rdy, pushed); end
    actbuf_wr_req = 1'b1;
    clk_step();
    nvec++; if (busy !== 1'b1 || actbuf_wr_vld !== 1'b0) begin nerr++; $display("FAIL basic_lat0 got busy=%0b vld=%0b exp 1/0", busy, actbuf_wr_vld); end
    clk_step();
    nvec++; if (actbuf_wr_vld !== 1'b1 || actbuf_wr_data !== BASE) begin nerr++; $display("FAIL basic_first got vld=%0b data=%h exp 1/%h", actbuf_wr_vld, actbuf_wr_data, BASE); end
    popped = 1;
    for (int k = 0; k < 35; k++) begin
      clk_step();
      if (actbuf_wr_vld) begin
        nvec++; if (actbuf_wr_data !== BASE + DW'(popped)) begin nerr++; $display("FAIL basic_data got %h exp %h", actbuf_wr_data, BASE + DW'(popped)); end
        popped++;
      end else if (popped < 27) gaps++;
      nvec++; if (tile_done !== (actbuf_wr_vld && popped == 27)) begin nerr++; $display("FAIL basic_done got %0b at word %0d", tile_done, popped); end
    end
    nvec++; if (popped != 27 || gaps != 0) begin nerr++; $display("FAIL basic_count got words=%0d gaps=%0d exp 27/0", popped, gaps); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL basic_hold_done got busy=%0b exp 1", busy); end
    in_vld = 1'b0;
    actbuf_wr_req = 1'b0;
    clk_step();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL basic_idle got busy=%0b exp 0", busy); end
  endtask

  task automatic test_stall();
    int gaps = 0;
    do_reset();
    cfg_tile_words = 16'd27;
    actbuf_wr_req = 1'b1;
    for (int k = 0; k < 50; k++) begin
      in_vld = (k < 5 || k >= 10);
      clk_step();
      if (actbuf_wr_vld) begin
        nvec++; if (actbuf_wr_data !== BASE + DW'(popped)) begin nerr++; $display("FAIL stall_data got %h exp %h", actbuf_wr_data, BASE + DW'(popped)); end
        popped++;
      end else if (popped > 0 && popped < 27) gaps++;
      nvec++; if (tile_done !== (actbuf_wr_vld && popped == 27)) begin nerr++; $display("FAIL stall_done got %0b at word %0d", tile_done, popped); end
    end
    nvec++; if (popped != 27 || gaps != 5) begin nerr++; $display("FAIL stall_count got words=%0d gaps=%0d exp 27/5", popped, gaps); end
`ifdef ACT_LOADER_STALL_CNT_EN
    nvec++; if (stall_cnt !== 32'd5) begin nerr++; $display("FAIL stall_cnt got %0d exp 5", stall_cnt); end
`endif
    in_vld = 1'b0;
    actbuf_wr_req = 1'b0;
    clk_step();
  endtask

  task automatic test_backpressure();
    int dn = 0;
    do_reset();
    actbuf_wr_req = 1'b0;
    in_vld = 1'b1;
    for (int k = 0; k < 10; k++) begin
      nvec++; if (in_rdy !== (k < 8)) begin nerr++; $display("FAIL bp_in_rdy got %0b at offer %0d", in_rdy, k); end
      clk_step();
    end
    nvec++; if (pushed != 8) begin nerr++; $display("FAIL bp_accepted got %0d exp 8", pushed); end
    cfg_tile_words = 16'd10;
    actbuf_wr_req = 1'b1;
    clk_step();
    nvec++; if (in_rdy !== 1'b0) begin nerr++; $display("FAIL bp_still_full got %0b exp 0", in_rdy); end
    clk_step();
    nvec++; if (in_rdy !== 1'b1 || actbuf_wr_vld !== 1'b1 || actbuf_wr_data !== BASE) begin nerr++; $display("FAIL bp_free got rdy=%0b vld=%0b data=%h", in_rdy, actbuf_wr_vld, actbuf_wr_data); end
    popped = 1;
    for (int k = 0; k < 20; k++) begin
      in_vld = pushed < 10;
      clk_step();
      if (actbuf_wr_vld) begin
        nvec++; if (actbuf_wr_data !== BASE + DW'(popped)) begin nerr++; $display("FAIL bp_data got %h exp %h", actbuf_wr_data, BASE + DW'(popped)); end
        popped++;
      end
      if (tile_done) dn++;
    end
    nvec++; if (popped != 10 || pushed != 10 || dn != 1) begin nerr++; $display("FAIL bp_total got out=%0d in=%0d done=%0d exp 10/10/1", popped, pushed, dn); end
    in_vld = 1'b0;
    actbuf_wr_req = 1'b0;
    clk_step();
  endtask

  task automatic test_abort();
    int ep = 0;
    do_reset();
    cfg_tile_words = 16'd27;
    in_vld = 1'b1;
    repeat (8) clk_step();
    actbuf_wr_req = 1'b1;
    for (int k = 0; k < 30 && popped < 10; k++) begin
      clk_step();
      if (actbuf_wr_vld) begin
        nvec++; if (actbuf_wr_data !== BASE + DW'(popped)) begin nerr++; $display("FAIL abort_data got %h exp %h", actbuf_wr_data, BASE + DW'(popped)); end
        popped++;
      end
    end
    actbuf_wr_req = 1'b0;
    in_vld = 1'b0;
    clk_step();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL abort_idle got busy=%0b exp 0", busy); end
    for (int k = 0; k < 3; k++) begin
      nvec++; if (actbuf_wr_vld !== 1'b0) begin nerr++; $display("FAIL abort_novld got %0b exp 0 at cycle %0d", actbuf_wr_vld, k); end
      clk_step();
    end
    actbuf_wr_req = 1'b1;
    in_vld = 1'b1;
    for (int k = 0; k < 45; k++) begin
      clk_step();
      if (actbuf_wr_vld) begin
        nvec++; if (actbuf_wr_data !== BASE + DW'(popped)) begin nerr++; $display("FAIL abort_resume_data got %h exp %h", actbuf_wr_data, BASE + DW'(popped)); end
        popped++;
        ep++;
      end
      nvec++; if (tile_done !== (actbuf_wr_vld && ep == 27)) begin nerr++; $display("FAIL abort_resume_done got %0b at word %0d", tile_done, ep); end
    end
    nvec++; if (ep != 27) begin nerr++; $display("FAIL abort_resume_count got %0d exp 27", ep); end
    actbuf_wr_req = 1'b0;
    in_vld = 1'b0;
    clk_step();
  endtask

  task automatic test_edge_reset();
    int dn = 0;
    do_reset();
    cfg_tile_words = 16'd0;
    in_vld = 1'b1;
    repeat (3) clk_step();
    in_vld = 1'b0;
    actbuf_wr_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      clk_step();
      if (actbuf_wr_vld) begin
        nvec++; if (actbuf_wr_data !== BASE + DW'(popped)) begin nerr++; $display("FAIL zero_data got %h exp %h", actbuf_wr_data, BASE + DW'(popped)); end
        popped++;
      end
      if (tile_done) dn++;
    end
    nvec++; if (popped != 1 || dn != 1 || busy !== 1'b1) begin nerr++; $display("FAIL zero_tile got words=%0d done=%0d busy=%0b exp 1/1/1", popped, dn, busy); end
    actbuf_wr_req = 1'b0;
    clk_step();
    cfg_tile_words = 16'd27;
    actbuf_wr_req = 1'b1;
    in_vld = 1'b1;
    repeat (3) clk_step();
    nvec++; if (actbuf_wr_vld !== 1'b1 || busy !== 1'b1) begin nerr++; $display("FAIL midfill_active got vld=%0b busy=%0b exp 1/1", actbuf_wr_vld, busy); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (actbuf_wr_vld !== 1'b0) begin nerr++; $display("FAIL midrst_vld got %0b exp 0", actbuf_wr_vld); end
    nvec++; if (actbuf_wr_data !== '0) begin nerr++; $display("FAIL midrst_data got %h exp 0", actbuf_wr_data); end
    nvec++; if (tile_done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL midrst_done_busy got %0b/%0b exp 0/0", tile_done, busy); end
    nvec++; if (in_rdy !== 1'b1) begin nerr++; $display("FAIL midrst_in_rdy got %0b exp 1", in_rdy); end
    in_vld = 1'b0;
    @(posedge clk_l);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clk_step();
      nvec++; if (actbuf_wr_vld !== 1'b0) begin nerr++; $display("FAIL postrst_vld got %0b exp 0 at cycle %0d", actbuf_wr_vld, k); end
    end
    actbuf_wr_req = 1'b0;
    clk_step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_abort();
    test_edge_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing the scenarios");
    $fatal(1);
  end
endmodule
